jt12_wrfifo: RTL

Host-side write buffer that sits directly upstream of the jt12 core. Accepts single-cycle register writes (address/data pairs) from the CPU bus, queues them in a FIFO, and replays them to jt12's `din/addr/cs_n/wr_n` port with correct strobe timing. After each data write it holds off until the chip is no longer busy, so the host never has to poll the YM status itself.

---
 rtl/jt12_wrfifo_if.sv | 33 +++
 rtl/jt12_wrfifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/jt12_wrfifo_if.sv
// Host/jt12 bus bundle for the jt12 write buffer.
//   host_din/host_addr/host_wr : CPU register write request
//   host_full/host_level/host_ovf/bridge_busy : buffer status
//   ym_din/ym_addr/ym_cs_n/ym_wr_n : jt12 write port, ym_dout : jt12 status read
// Modports: slave = the buffer itself, master = the host/chip side driving it.
interface jt12_wrfifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [7:0]            host_din;
    logic [1:0]            host_addr;
    logic                  host_wr;
    logic                  host_full;
    logic [DEPTH_LOG2:0]   host_level;
    logic                  host_ovf;
    logic                  bridge_busy;
    logic [7:0]            ym_din;
    logic [1:0]            ym_addr;
    logic                  ym_cs_n;
    logic                  ym_wr_n;
    logic [7:0]            ym_dout;

    modport slave (
        input  host_din, host_addr, host_wr, ym_dout,
        output host_full, host_level, host_ovf, bridge_busy,
               ym_din, ym_addr, ym_cs_n, ym_wr_n
    );

    modport master (
        output host_din, host_addr, host_wr, ym_dout,
        input  host_full, host_level, host_ovf, bridge_busy,
               ym_din, ym_addr, ym_cs_n, ym_wr_n
    );
endinterface

// File: rtl/jt12_wrfifo.sv
// jt12_wrfifo: queues host register writes and replays them to jt12 with
// SETUP / STROBE / HOLD timing, then waits out the chip busy period after
// every data-port write.
// Ports: clk, rst_n (async active-low), bus (jt12_wrfifo_if.slave).
// Parameters: DEPTH_LOG2 (FIFO depth 2^N), WR_LEN (wr_n low cycles),
//             BUSY_WAIT (fixed post-data-write wait without polling).
// Build option: JT12_BUSY_POLL_EN - poll ym_dout[7] in WAIT instead of a
//               fixed delay (1024-cycle timeout).
module jt12_wrfifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WR_LEN     = 2,
    parameter int unsigned BUSY_WAIT  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    jt12_wrfifo_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned CW    = 10;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic           full_q, full_d, ovf_q, ovf_d, busy_q, busy_d;
    logic           cs_n_q, cs_n_d, wr_n_q, wr_n_d;
    logic [1:0]     addr_q, addr_d;
    logic [7:0]     din_q, din_d;
    entry_t         mem [DEPTH];
    entry_t         head;
    logic           push, pop;

    // Full is the registered flag, so a push on full is dropped even with a same-cycle pop
    assign push = bus.host_wr && !full_q;
    assign pop  = (state_q == S_IDLE) && (level_q != '0);
    assign head = mem[rptr_q[DEPTH_LOG2-1:0]];

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= '{addr: bus.host_addr, data: bus.host_din};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Next state, FIFO bookkeeping and next output values
    always_comb begin
        state_d = state_q;
        cs_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            S_IDLE:   if (pop) state_d = S_SETUP;
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: if (cnt_q == CW'(WR_LEN - 1)) state_d = S_HOLD;
            // addr_q still holds the replayed port address here
            S_HOLD:   state_d = addr_q[0] ? S_WAIT : S_IDLE;
            S_WAIT: begin
`ifdef JT12_BUSY_POLL_EN
                // status ignored for the first two WAIT cycles
                if ((cnt_q == CW'(1023)) || ((cnt_q >= CW'(2)) && !bus.ym_dout[7])) begin
                    state_d = S_IDLE;
                end
`else
                if (cnt_q == CW'(BUSY_WAIT - 1)) state_d = S_IDLE;
`endif
            end
            default:  state_d = S_IDLE;
        endcase

        // cycle counter restarts on every state change
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);

        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        level_d = level_q + PW'(push) - PW'(pop);
        full_d  = (level_d == PW'(DEPTH));
        ovf_d   = ovf_q | (bus.host_wr & full_q);
        busy_d  = (state_d != S_IDLE) || (level_d != '0);

        if (pop) begin
            addr_d = head.addr;
            din_d  = head.data;
        end

        // bus pins reflect the state being entered
        case (state_d)
            S_SETUP:  cs_n_d = 1'b0;
            S_STROBE: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
            end
            S_HOLD:   cs_n_d = 1'b0;
            S_WAIT: begin
`ifdef JT12_BUSY_POLL_EN
                cs_n_d = 1'b0;
                addr_d = '0;
`else
                cs_n_d = 1'b1;
`endif
            end
            default:  cs_n_d = 1'b1;
        endcase
    end

    assign bus.host_full   = full_q;
    assign bus.host_level  = level_q;
    assign bus.host_ovf    = ovf_q;
    assign bus.bridge_busy = busy_q;
    assign bus.ym_din      = din_q;
    assign bus.ym_addr     = addr_q;
    assign bus.ym_cs_n     = cs_n_q;
    assign bus.ym_wr_n     = wr_n_q;
endmodule
